req_router: RTL



---
 rtl/req_router.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/req_router.sv
// req_router: steers CPU requests to the memory or peripheral port by address,
// tracks the target of the active write burst, and returns read data strictly
// in request order through a small order FIFO.
module req_router #(
    parameter logic [3:0]  PER_BASE = 4'hF,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    // upstream request
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_len_i,
    input  logic [3:0]  req_mask_i,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    // upstream write beats
    input  logic        write_valid_i,
    input  logic [31:0] write_data_i,
    // upstream read return
    output logic        read_valid_o,
    input  logic        read_ack_i,
    output logic [31:0] read_data_o,
    // memory port
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [2:0]  mem_req_len_o,
    output logic [3:0]  mem_req_mask_o,
    output logic [31:0] mem_req_addr_o,
    output logic        mem_req_we_o,
    output logic        mem_write_valid_o,
    output logic [31:0] mem_write_data_o,
    input  logic        mem_read_valid_i,
    output logic        mem_read_ack_o,
    input  logic [31:0] mem_read_data_i,
    // peripheral port
    output logic        per_req_valid_o,
    input  logic        per_req_ready_i,
    output logic [2:0]  per_req_len_o,
    output logic [3:0]  per_req_mask_o,
    output logic [31:0] per_req_addr_o,
    output logic        per_req_we_o,
    output logic        per_write_valid_o,
    output logic [31:0] per_write_data_o,
    input  logic        per_read_valid_i,
    output logic        per_read_ack_o,
    input  logic [31:0] per_read_data_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LEN_W = 3;

    // One outstanding read: which port answers it and how many beats it owes.
    typedef struct packed {
        logic             tgt;
        logic [LEN_W-1:0] beats;
    } ord_t;

    ord_t             fifo_q [DEPTH];
    ord_t             head;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic             wr_tgt_q, wr_tgt_d;

    logic [LEN_W-1:0] beats;
    logic             sel_per, port_ready, blocked, full, empty;
    logic             accept, push, pop, rd_beat;

    // Request fields fan out to both ports unchanged.
    assign mem_req_len_o    = req_len_i;
    assign mem_req_mask_o   = req_mask_i;
    assign mem_req_addr_o   = req_addr_i;
    assign mem_req_we_o     = req_we_i;
    assign per_req_len_o    = req_len_i;
    assign per_req_mask_o   = req_mask_i;
    assign per_req_addr_o   = req_addr_i;
    assign per_req_we_o     = req_we_i;
    assign mem_write_data_o = write_data_i;
    assign per_write_data_o = write_data_i;

    // Request steering and back-pressure; full uses registered occupancy only.
    always_comb begin
        beats           = (req_len_i == LEN_W'(0)) ? LEN_W'(1) : req_len_i;
        sel_per         = (req_addr_i[31:28] == PER_BASE);
        full            = (count_q == CNT_W'(DEPTH));
        blocked         = rst | (req_we_i ? (wr_cnt_q != LEN_W'(0)) : full);
        port_ready      = sel_per ? per_req_ready_i : mem_req_ready_i;
        req_ready_o     = port_ready & ~blocked;
        mem_req_valid_o = req_valid_i & ~sel_per & ~blocked;
        per_req_valid_o = req_valid_i &  sel_per & ~blocked;
        accept          = req_valid_i & req_ready_o;
        push            = accept & ~req_we_i;
    end

    // Write-beat routing: active burst uses its latched target, a beat in the
    // accept cycle follows the new request, anything else is dropped.
    always_comb begin
        wr_cnt_d          = wr_cnt_q;
        wr_tgt_d          = wr_tgt_q;
        mem_write_valid_o = 1'b0;
        per_write_valid_o = 1'b0;
        if (!rst) begin
            if (wr_cnt_q != LEN_W'(0)) begin
                if (write_valid_i) begin
                    mem_write_valid_o = ~wr_tgt_q;
                    per_write_valid_o =  wr_tgt_q;
                    wr_cnt_d          = wr_cnt_q - LEN_W'(1);
                end
            end else if (accept && req_we_i) begin
                wr_tgt_d = sel_per;
                if (write_valid_i) begin
                    mem_write_valid_o = ~sel_per;
                    per_write_valid_o =  sel_per;
                    wr_cnt_d          = beats - LEN_W'(1);
                end else begin
                    wr_cnt_d = beats;
                end
            end
        end
    end

    // Read return: only the head port is visible upstream and sees the ack.
    always_comb begin
        empty          = (count_q == CNT_W'(0));
        head           = fifo_q[rd_ptr_q];
        read_valid_o   = 1'b0;
        read_data_o    = 32'h0;
        mem_read_ack_o = 1'b0;
        per_read_ack_o = 1'b0;
        rd_beat        = 1'b0;
        pop            = 1'b0;
        rd_cnt_d       = rd_cnt_q;
        if (!rst && !empty) begin
            if (head.tgt) begin
                read_valid_o   = per_read_valid_i;
                read_data_o    = per_read_data_i;
                per_read_ack_o = read_ack_i;
            end else begin
                read_valid_o   = mem_read_valid_i;
                read_data_o    = mem_read_data_i;
                mem_read_ack_o = read_ack_i;
            end
            rd_beat = read_valid_o & read_ack_i;
            if (rd_beat) begin
                if (rd_cnt_q + LEN_W'(1) == head.beats) begin
                    pop      = 1'b1;
                    rd_cnt_d = LEN_W'(0);
                end else begin
                    rd_cnt_d = rd_cnt_q + LEN_W'(1);
                end
            end
        end
    end

    // Order FIFO pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Routing state registers; reset abandons any in-flight burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wr_tgt_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_tgt_q <= wr_tgt_d;
        end
    end

    // Order FIFO storage; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{tgt: sel_per, beats: beats};
        end
    end

endmodule
